pipeline_fetch_btb: RTL and testbench

- Instruction-fetch (IF) stage of the pipelined 8085 core; sits directly upstream of the ID stage.
- Owns the program counter and drives the instruction-memory address.
- Holds a small fully-associative jump lookup table (branch target buffer, BTB) for next-PC prediction.
- Produces the IF/ID pipeline register, including the lookup index that travels down the pipe to EX.
- Accepts jump-resolution and stall feedback from ID/EX.

---
 rtl/pipeline_fetch_btb.sv | 155 +++++++++++++++
 tb/tb_pipeline_fetch_btb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fetch_btb.sv
// IF stage of the pipelined 8085 core: PC, next-PC lookup table, IF/ID reg.
// Macro FETCH_BTB_EN enables the jump lookup table; undefined = predict not-taken.
module pipeline_fetch_btb #(
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_data,
  input  logic              stall,
  input  logic              ex_resolve,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_predicted,
  input  logic [IDX_W-1:0]  ex_lookupindex,
  output logic [7:0]        if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic              if_id_valid,
  output logic              if_id_predicted,
  output logic [IDX_W-1:0]  if_id_lookupindex,
  output logic              stall_jump
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        instr_q, instr_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic              valid_q, valid_d;
  logic              pred_q, pred_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              sj_q, sj_d;

  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [ADDR_W-1:0] hit_tgt;
  logic              mispredict;

`ifdef FETCH_BTB_EN
  localparam int N = 2 ** IDX_W;

  logic [N-1:0]      vld_q;
  logic [ADDR_W-1:0] tag_q [N];
  logic [ADDR_W-1:0] tgt_q [N];
  logic [IDX_W-1:0]  ptr_q;
  logic              tgt_miss;

  // Associative match on the current PC; lowest index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vld_q[i] && tag_q[i] == pc_q) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign hit_tgt    = tgt_q[hit_idx];
  assign tgt_miss   = tgt_q[ex_lookupindex] != ex_target;
  assign mispredict = ex_resolve &
                      ((ex_taken != ex_predicted) |
                       (ex_taken & ex_predicted & tgt_miss));

  // Table training from EX; independent of stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      ptr_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (ex_resolve) begin
      if (ex_taken && !ex_predicted) begin
        vld_q[ptr_q] <= 1'b1;
        tag_q[ptr_q] <= ex_pc;
        tgt_q[ptr_q] <= ex_target;
        ptr_q        <= ptr_q + IDX_W'(1);
      end else if (ex_taken && ex_predicted && tgt_miss) begin
        tgt_q[ex_lookupindex] <= ex_target;
      end else if (!ex_taken && ex_predicted) begin
        vld_q[ex_lookupindex] <= 1'b0;
      end
    end
  end
`else
  logic unused_pred_inputs;

  assign hit        = 1'b0;
  assign hit_idx    = '0;
  assign hit_tgt    = '0;
  assign mispredict = ex_resolve & ex_taken;
  assign unused_pred_inputs = &{1'b0, ex_predicted, ex_lookupindex};
`endif

  // Next-PC / IF-ID selection: redirect > stall > hit > sequential.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    pred_d  = pred_q;
    idx_d   = idx_q;
    sj_d    = 1'b0;
    if (mispredict) begin
      pc_d    = ex_taken ? ex_target : ex_pc + ADDR_W'(1);
      instr_d = '0;
      ifpc_d  = '0;
      valid_d = 1'b0;
      pred_d  = 1'b0;
      idx_d   = '0;
      sj_d    = 1'b1;
    end else if (!stall) begin
      instr_d = imem_data;
      ifpc_d  = pc_q;
      valid_d = 1'b1;
      pred_d  = hit;
      idx_d   = hit ? hit_idx : '0;
      pc_d    = hit ? hit_tgt : pc_q + ADDR_W'(1);
    end
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      pred_q  <= 1'b0;
      idx_q   <= '0;
      sj_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      pred_q  <= pred_d;
      idx_q   <= idx_d;
      sj_q    <= sj_d;
    end
  end

  assign imem_addr         = pc_q;
  assign if_id_instr       = instr_q;
  assign if_id_pc          = ifpc_q;
  assign if_id_valid       = valid_q;
  assign if_id_predicted   = pred_q;
  assign if_id_lookupindex = idx_q;
  assign stall_jump        = sj_q;

endmodule

// File: tb/tb_pipeline_fetch_btb.sv
// Bench for pipeline_fetch_btb: vector table plus scoreboard queue.
// Table-trained cases run only when FETCH_BTB_EN is defined.
module tb_pipeline_fetch_btb;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       stall;
  logic       ex_resolve;
  logic       ex_taken;
  logic [7:0] ex_target;
  logic [7:0] ex_pc;
  logic       ex_predicted;
  logic [0:0] ex_lookupindex;
  logic [7:0] if_id_instr;
  logic [7:0] if_id_pc;
  logic       if_id_valid;
  logic       if_id_predicted;
  logic [0:0] if_id_lookupindex;
  logic       stall_jump;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       st, res, tk, pr;
    logic [0:0] li;
    logic [7:0] tgt, xpc;
    logic [7:0] e_pc;
    logic       e_v;
    logic [7:0] e_ifpc;
    logic       e_pr;
    logic [0:0] e_idx;
    logic       e_sj;
  } vec_t;

  typedef struct {
    logic [7:0] pc, ifpc, instr;
    logic       v, pr, sj;
    logic [0:0] idx;
  } exp_t;

  vec_t tbl[$];
  vec_t seq[$];
  exp_t sb[$];

  pipeline_fetch_btb dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .ex_resolve(ex_resolve), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pc(ex_pc),
    .ex_predicted(ex_predicted), .ex_lookupindex(ex_lookupindex),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .if_id_predicted(if_id_predicted),
    .if_id_lookupindex(if_id_lookupindex), .stall_jump(stall_jump)
  );

  always #5 clk = ~clk;

  // Instruction memory model: distinct opcode per address.
  assign imem_data = imem_addr ^ 8'h5A;

  function automatic vec_t mk(
    input logic st, res, tk, pr, input logic [0:0] li,
    input logic [7:0] tgt, xpc, e_pc, input logic e_v,
    input logic [7:0] e_ifpc, input logic e_pr,
    input logic [0:0] e_idx, input logic e_sj);
    vec_t v;
    v.st = st; v.res = res; v.tk = tk; v.pr = pr; v.li = li;
    v.tgt = tgt; v.xpc = xpc; v.e_pc = e_pc; v.e_v = e_v;
    v.e_ifpc = e_ifpc; v.e_pr = e_pr; v.e_idx = e_idx; v.e_sj = e_sj;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    stall = 0; ex_resolve = 0; ex_taken = 0; ex_predicted = 0;
    ex_lookupindex = 0; ex_target = 0; ex_pc = 0;
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e, g;
    stall = v.st; ex_resolve = v.res; ex_taken = v.tk;
    ex_predicted = v.pr; ex_lookupindex = v.li;
    ex_target = v.tgt; ex_pc = v.xpc;
    e.pc = v.e_pc; e.v = v.e_v; e.ifpc = v.e_ifpc;
    e.instr = v.e_v ? (v.e_ifpc ^ 8'h5A) : 8'h00;
    e.pr = v.e_pr; e.idx = v.e_idx; e.sj = v.e_sj;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      g = sb.pop_front();
      chk({tag, " pc"}, imem_addr, g.pc);
      chk({tag, " valid"}, 8'(if_id_valid), 8'(g.v));
      chk({tag, " ifpc"}, if_id_pc, g.ifpc);
      chk({tag, " instr"}, if_id_instr, g.instr);
      chk({tag, " pred"}, 8'(if_id_predicted), 8'(g.pr));
      chk({tag, " idx"}, 8'(if_id_lookupindex), 8'(g.idx));
      chk({tag, " sj"}, 8'(stall_jump), 8'(g.sj));
    end
    clr_in();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pc"}, imem_addr, 8'h00);
    chk({tag, " valid"}, 8'(if_id_valid), 8'h00);
    chk({tag, " ifpc"}, if_id_pc, 8'h00);
    chk({tag, " instr"}, if_id_instr, 8'h00);
    chk({tag, " pred"}, 8'(if_id_predicted), 8'h00);
    chk({tag, " sj"}, 8'(stall_jump), 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // st res tk pr li tgt xpc | pc v ifpc pr idx sj
    tbl.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h01,1,8'h00,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h02,1,8'h01,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h03,1,8'h02,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,8'h20,8'h05, 8'h20,0,8'h00,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h21,1,8'h20,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,8'h00,8'h21, 8'h22,1,8'h21,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,8'h00,8'h00, 8'h22,1,8'h21,0,0,0));
    tbl.push_back(mk(1,1,1,0,0,8'hFE,8'h40, 8'hFE,0,8'h00,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,8'h00,8'h00, 8'hFE,0,8'h00,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'hFF,1,8'hFE,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h00,1,8'hFF,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h01,1,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,8'h10,8'hFF, 8'h10,0,8'h00,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h11,1,8'h10,0,0,0));

`ifdef FETCH_BTB_EN
    seq.push_back(mk(0,1,1,0,0,8'h20,8'h05, 8'h20,0,8'h00,0,0,1));
    seq.push_back(mk(0,1,1,0,0,8'h05,8'h50, 8'h05,0,8'h00,0,0,1));
    seq.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h20,1,8'h05,1,0,0));
    seq.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h21,1,8'h20,0,0,0));
    seq.push_back(mk(0,1,1,1,0,8'h30,8'h05, 8'h30,0,8'h00,0,0,1));
    seq.push_back(mk(0,1,1,1,0,8'h30,8'h05, 8'h31,1,8'h30,0,0,0));
    seq.push_back(mk(0,1,1,0,0,8'h05,8'h60, 8'h05,0,8'h00,0,0,1));
    seq.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h06,1,8'h05,0,0,0));
    seq.push_back(mk(0,1,1,0,0,8'h5F,8'h70, 8'h5F,0,8'h00,0,0,1));
    seq.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h60,1,8'h5F,0,0,0));
    seq.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h05,1,8'h60,1,0,0));
    seq.push_back(mk(0,1,0,1,0,8'h00,8'h60, 8'h61,0,8'h00,0,0,1));
    seq.push_back(mk(0,1,1,1,1,8'h60,8'h70, 8'h60,0,8'h00,0,0,1));
    seq.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h61,1,8'h60,0,0,0));
    seq.push_back(mk(0,1,1,0,0,8'h70,8'h90, 8'h70,0,8'h00,0,0,1));
    seq.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h60,1,8'h70,1,1,0));
`else
    seq.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h01,1,8'h00,0,0,0));
    seq.push_back(mk(0,1,1,0,0,8'h80,8'h01, 8'h80,0,8'h00,0,0,1));
    seq.push_back(mk(1,0,0,0,0,8'h00,8'h00, 8'h80,0,8'h00,0,0,0));
    seq.push_back(mk(0,0,0,0,0,8'h00,8'h00, 8'h81,1,8'h80,0,0,0));
`endif

    clr_in();
    rst = 1'b1;
    #3;
    chk_reset("reset");
    #9;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("vec%0d", i));

`ifndef FETCH_BTB_EN
    step(mk(0,1,0,1,0,8'h00,8'h10, 8'h12,1,8'h11,0,0,0), "nt_pred");
`endif

    // Asynchronous reset between edges clears in-flight state at once.
    rst = 1'b1;
    #2;
    chk_reset("midreset");
    #2;
    rst = 1'b0;

    for (int i = 0; i < seq.size(); i++)
      step(seq[i], $sformatf("seq%0d", i));

    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
